// File: rtl/instr_encoder_loader.sv
// Packs instruction fields into 17-bit words, buffers them, and writes them to instruction memory.
// Optional macro ENC_ILLEGAL_TRAP_EN: drop illegal opcodes and count them instead of writing NOPs.
module instr_encoder_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_ra,
  input  logic [2:0]        in_rb,
  input  logic [5:0]        in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [16:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic [15:0]       wr_count,
  output logic              err_illegal,
  output logic [7:0]        err_count
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state_q, state_d;

  logic [16:0] fifo [FIFO_DEPTH];
  logic [PW:0] rptr, wptr_f, cnt, cnt_nxt;
  logic        fifo_empty, fifo_full;
  logic [16:0] enc;
  logic        accept, trap, push, pop;
  logic [ADDR_W-1:0] wr_ptr;

  // Field packing by opcode class; NOP and every unlisted opcode pack to zero.
  always_comb begin
    enc = '0;
    case (in_op)
      5'b00010, 5'b00101, 5'b01100, 5'b01101,
      5'b01111, 5'b01010, 5'b00100, 5'b10000: enc = {in_op, in_rd, in_ra, in_rb, 3'b000};
      5'b01110, 5'b10100, 5'b10010:           enc = {in_op, in_rd, in_ra, in_imm};
      5'b00001, 5'b01001, 5'b00110, 5'b10001: enc = {in_op, in_rd, in_ra, 6'b0};
      5'b00011, 5'b01000:                     enc = {in_op, 3'b000, in_ra, in_imm};
      5'b01011, 5'b00111, 5'b10011:           enc = {in_op, 3'b000, in_ra, 6'b0};
      default:                                enc = '0;
    endcase
  end

  assign cnt        = wptr_f - rptr;
  assign fifo_empty = (rptr == wptr_f);
  assign fifo_full  = (rptr[PW-1:0] == wptr_f[PW-1:0]) && (rptr[PW] != wptr_f[PW]);
  assign in_ready   = !fifo_full;
  assign accept     = in_valid && in_ready;

`ifdef ENC_ILLEGAL_TRAP_EN
  assign trap = accept && (in_op >= 5'b10101);
`else
  assign trap = 1'b0;
`endif

  assign push = accept && !trap;
  // Head word is presented as soon as it lands so a fresh word reaches memory one cycle after acceptance.
  assign mem_we    = (state_q == WRITE) || !fifo_empty;
  assign pop       = mem_we && mem_ack;
  assign busy      = mem_we;
  assign mem_addr  = wr_ptr;
  assign mem_wdata = mem_we ? fifo[rptr[PW-1:0]] : 17'h00000;
  assign cnt_nxt   = cnt + (PW+1)'(push) - (PW+1)'(pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = (cnt_nxt != '0) ? WRITE : IDLE;
      WRITE:   if (pop)         state_d = (cnt_nxt != '0) ? WRITE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rptr     <= '0;
      wptr_f   <= '0;
      wr_ptr   <= '0;
      wr_count <= '0;
    end else begin
      state_q <= state_d;
      if (push) wptr_f <= wptr_f + (PW+1)'(1);
      if (pop)  rptr   <= rptr + (PW+1)'(1);
      if (load_start && !busy) begin
        wr_ptr   <= start_addr;
        wr_count <= '0;
      end else if (pop) begin
        wr_ptr   <= wr_ptr + ADDR_W'(1);
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr_f[PW-1:0]] <= enc;
  end

`ifdef ENC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      err_illegal <= trap;
      if (trap && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_illegal = 1'b0;
  assign err_count   = 8'h00;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding classes, backpressure, wrap, illegal handling, async reset.
module tb_instr_encoder_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [2:0]  in_rd = '0, in_ra = '0, in_rb = '0;
  logic [5:0]  in_imm = '0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [16:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic [15:0] wr_count;
  logic        err_illegal;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_err = 0;

  instr_encoder_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy),
    .wr_count(wr_count), .err_illegal(err_illegal), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [5:0] imm);
    in_op = op; in_rd = rd; in_ra = ra; in_rb = rb; in_imm = imm; in_valid = 1'b1;
  endtask

  task automatic do_load(input logic [7:0] a);
    start_addr = a; load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wrcnt"}, wr_count, 0);
    chk({tag, "_errp"}, err_illegal, 0);
    chk({tag, "_errc"}, err_count, 0);
  endtask

  // One bundle with ack high: check the single write it produces, then the idle cycle after.
  task automatic single(input string tag, input logic [4:0] op, input logic [2:0] rd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic [5:0] imm,
                        input logic [7:0] exp_addr, input logic [16:0] exp_word,
                        input logic [15:0] exp_cnt);
    drive(op, rd, ra, rb, imm);
    step();
    in_valid = 1'b0;
    chk({tag, "_we"}, mem_we, 1);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    chk({tag, "_wdata"}, mem_wdata, exp_word);
    step();
    chk({tag, "_we_off"}, mem_we, 0);
    chk({tag, "_wrcnt"}, wr_count, exp_cnt);
  endtask

  initial begin
    #2;
    chk_reset_vals("rst");
    step(); step();
    rst = 1'b0;
    step();

    mem_ack = 1'b1;
    do_load(8'h10);
    chk("load_cnt", wr_count, 0);
    chk("load_addr", mem_addr, 8'h10);
    single("add",  5'b01101, 3'd3, 3'd1, 3'd2, 6'h15, 8'h10, 17'h0D650, 16'd1);
    single("addi", 5'b10100, 3'd2, 3'd2, 3'd7, 6'h2A, 8'h11, 17'h144AA, 16'd2);
    single("bz",   5'b00011, 3'd7, 3'd5, 3'd6, 6'h3F, 8'h12, 17'h0317F, 16'd3);
    single("ld",   5'b01001, 3'd1, 3'd2, 3'd7, 6'h3F, 8'h13, 17'h09280, 16'd4);
    single("cmp",  5'b00111, 3'd7, 3'd3, 3'd7, 6'h3F, 8'h14, 17'h070C0, 16'd5);
    single("nop",  5'b00000, 3'd7, 3'd7, 3'd7, 6'h3F, 8'h15, 17'h00000, 16'd6);

    // Backpressure: ADD rd=0 ra=0 rb=i gives 17'h0D000 | i<<3.
    mem_ack = 1'b0;
    do_load(8'h20);
    for (int i = 0; i < 4; i++) begin
      drive(5'b01101, 3'd0, 3'd0, 3'(i), 6'h00);
      chk($sformatf("bp_ready%0d", i), in_ready, 1);
      step();
    end
    drive(5'b01101, 3'd0, 3'd0, 3'd4, 6'h00);
    chk("bp_full", in_ready, 0);
    chk("bp_hold_addr", mem_addr, 8'h20);
    chk("bp_hold_data", mem_wdata, 17'h0D000);
    step();
    in_valid = 1'b0;
    step();
    chk("bp_hold_we2", mem_we, 1);
    chk("bp_hold_data2", mem_wdata, 17'h0D000);
    do_load(8'h77);
    chk("bp_load_ignored", mem_addr, 8'h20);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_we%0d", i), mem_we, 1);
      chk($sformatf("drain_addr%0d", i), mem_addr, 8'h20 + 8'(i));
      chk($sformatf("drain_data%0d", i), mem_wdata, 17'h0D000 | 17'(i << 3));
      step();
    end
    chk("drain_done", mem_we, 0);
    chk("drain_cnt", wr_count, 4);

    // Address wrap with back-to-back words.
    do_load(8'hFF);
    drive(5'b01110, 3'd1, 3'd1, 3'd0, 6'h01);
    step();
    chk("wrap_addr0", mem_addr, 8'hFF);
    chk("wrap_data0", mem_wdata, 17'h0E241);
    drive(5'b01110, 3'd1, 3'd1, 3'd0, 6'h02);
    step();
    in_valid = 1'b0;
    chk("wrap_we1", mem_we, 1);
    chk("wrap_addr1", mem_addr, 8'h00);
    chk("wrap_data1", mem_wdata, 17'h0E242);
    step();
    chk("wrap_idle", mem_we, 0);
    chk("wrap_cnt", wr_count, 2);

    // Illegal opcode handling.
    drive(5'b11000, 3'd5, 3'd5, 3'd5, 6'h3F);
    chk("ill_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
`ifdef ENC_ILLEGAL_TRAP_EN
    chk("ill_we", mem_we, 0);
    chk("ill_pulse", err_illegal, 1);
    chk("ill_cnt1", err_count, 1);
    step();
    chk("ill_pulse_off", err_illegal, 0);
    drive(5'b11111, 3'd0, 3'd0, 3'd0, 6'h00);
    for (int i = 0; i < 299; i++) step();
    in_valid = 1'b0;
    step();
    chk("ill_sat", err_count, 255);
    chk("ill_sat_we", mem_we, 0);
    chk("ill_sat_cnt", wr_count, 2);
`else
    chk("ill_we", mem_we, 1);
    chk("ill_word", mem_wdata, 17'h00000);
    chk("ill_addr", mem_addr, 8'h01);
    chk("ill_pulse", err_illegal, 0);
    step();
    chk("ill_cnt", err_count, 0);
    chk("ill_wrcnt", wr_count, 3);
`endif

    // Asynchronous reset with words queued and a write outstanding.
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(5'b01101, 3'd1, 3'd1, 3'(i), 6'h00);
      step();
    end
    in_valid = 1'b0;
    chk("mid_we", mem_we, 1);
    chk("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("arst");
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("post_rst_we%0d", i), mem_we, 0);
    end
    chk("post_rst_cnt", wr_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Packs assembly-level instruction fields into the 17-bit instruction words consumed by the MCU instruction decoder. Writes them sequentially into instruction memory through a write/acknowledge handshake. The block sits between the host-side program download path and the instruction memory write port. It buffers up to FIFO_DEPTH encoded words and counts rejected opcodes.

## Interface
- ADDR_W, 8, instruction memory address width
- FIFO_DEPTH, 4, encoded-word buffer depth (power of two, ≥2)

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- load_start  in  1  one-cycle pulse: load start_addr into write pointer, clear wr_count
- start_addr  in  ADDR_W  first memory address of the program
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept bundle
- in_op  in  5  opcode
- in_rd  in  3  destination register (DA field)
- in_ra  in  3  source A (AA field)
- in_rb  in  3  source B (BA field)
- in_imm  in  6  immediate / branch offset
- mem_we  out  1  memory write request
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  17  encoded instruction
- mem_ack  in  1  memory accepted write this cycle
- busy  out  1  FIFO non-empty or write outstanding
- wr_count  out  16  words written since last load_start (wraps)
- err_illegal  out  1  one-cycle pulse on rejected opcode
- err_count  out  8  rejected opcodes, saturates at 255

## Operation
- Word layout: [16:12] op, [11:9] rd, [8:6] ra, [5:0] low field.
- The bundle is encoded combinationally at acceptance, and the 17-bit word is pushed to the FIFO. Encoding by class:
  - R-type (AND 00010, XOR 00101, SUB 01100, ADD 01101, MOV 01111, SLT 01010, ST 00100, JMP 10000): {op, rd, ra, rb, 000}.
  - Immediate (OR 01110, ADDI 10100, ADDIU 10010): {op, rd, ra, imm}.
  - Single-source (IN 00001, LD 01001, LSL 00110, JMPL 10001): {op, rd, ra, 000000}.
  - Branch (BZ 00011, BNZ 01000): {op, 000, ra, imm}.
  - Source-only (JR 01011, CMP 00111, OUT 10011): {op, 000, ra, 000000}.
  - NOP 00000: 17'h00000.
  - Illegal: op 10101–11111; handling is set by the Configuration section.
- Unused input fields are ignored and forced to zero in the word.
- Writer FSM:
  - IDLE → WRITE when the FIFO is non-empty. In WRITE, the head word is presented.
  - WRITE → pop; pointer += 1 on mem_ack. The next state is WRITE if the FIFO is still non-empty after the pop, else IDLE.
- Write pointer wraps modulo 2^ADDR_W with no flag. wr_count increments per acked write and wraps at 16 bits.
- load_start is honoured only when busy=0; otherwise it is ignored.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, wr_count=0, err_illegal=0, err_count=0. The FIFO is emptied and the FSM is in IDLE.
- Handshake: a bundle is accepted on a rising edge with in_valid && in_ready. in_ready = !fifo_full, registered-free (combinational from FIFO state).
- Latency: a bundle accepted at edge N into an empty FIFO with FSM IDLE drives mem_we=1 in cycle N+1.
- mem_we, mem_addr and mem_wdata are held stable until the edge where mem_ack=1. mem_ack while mem_we=0 is ignored.
- Back-to-back: the next word is presented in the cycle after the ack, so mem_we stays high. Peak rate is one word per cycle with mem_ack tied high.
- Full FIFO: in_ready=0. A pop and a push in the same cycle are allowed only when not full.
- Reset mid-write: mem_we drops immediately (asynchronous). Buffered words are discarded.

## Configuration
- ENC_ILLEGAL_TRAP_EN defined:
  - An illegal opcode is accepted (handshake completes) but not pushed.
  - err_illegal pulses high in the cycle after acceptance.
  - err_count increments, saturating at 255.
- Undefined:
  - An illegal opcode is encoded as NOP (17'h00000) and written normally.
  - err_illegal and err_count are tied to 0.

## Test plan
- ADD rd=3 ra=1 rb=2 imm=6'h15 after load_start with start_addr=8'h10, mem_ack tied 1 → mem_we one cycle, mem_addr=8'h10, mem_wdata=17'h0D650, wr_count=1.
- ADDI rd=2 ra=2 imm=6'h2A → 17'h144AA. BZ rd=7 ra=5 imm=6'h3F → 17'h0317F (rd forced to 0).
- mem_ack held 0 while 5 bundles are offered → 4 accepted, then in_ready=0. The first word is held stable. Releasing ack drains all 4 at consecutive addresses.
- start_addr=8'hFF, two words → addresses 8'hFF then 8'h00.
- op=5'b11000 with the macro defined → no write, err_illegal pulse, err_count=1. Repeated 300 times → err_count=255. Without the macro → writes 17'h00000.
- rst asserted while mem_we=1 with 3 words queued → all outputs return to reset values within the same cycle, and no further writes occur after release.
